// File: rtl/store_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : store_sequencer
// Description : Turns a byte/half/word store request into one or two
//               word-aligned, lane-masked bus writes. A store that crosses a
//               word boundary is split into two writes or rejected with err,
//               depending on SPLIT_MISALIGNED.
// Revision    : 1.0 - initial release
// ============================================================================
module store_sequencer #(
  parameter int                        SPLIT_MISALIGNED = 1,
  parameter int                        STORE_OP_WIDTH   = 2,
  parameter logic [STORE_OP_WIDTH-1:0] STORE_OP_SB      = STORE_OP_WIDTH'(0),
  parameter logic [STORE_OP_WIDTH-1:0] STORE_OP_SH      = STORE_OP_WIDTH'(1),
  parameter logic [STORE_OP_WIDTH-1:0] STORE_OP_SW      = STORE_OP_WIDTH'(2)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_data,
  input  logic [STORE_OP_WIDTH-1:0] req_storeop,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_wmask,
  output logic                      done,
  output logic                      err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] hi_data_q, hi_data_d;   // upper-word data for the second write
  logic [3:0]  hi_mask_q, hi_mask_d;   // upper-word lanes for the second write
  logic        cross_q, cross_d;       // latched request spans two words
  logic        err_q, err_d;

  logic [7:0]  w_base;
  logic [7:0]  w_m8;
  logic [63:0] w_d64;
  logic        w_op_ok;
  logic        w_cross;
  logic        w_reject;

  // Decode the incoming request into a two-word lane mask and shifted data.
  always_comb begin
    w_base  = 8'h00;
    w_op_ok = 1'b1;
    case (req_storeop)
      STORE_OP_SB: w_base = 8'h01;
      STORE_OP_SH: w_base = 8'h03;
      STORE_OP_SW: w_base = 8'h0F;
      default: begin
        w_base  = 8'h00;
        w_op_ok = 1'b0;
      end
    endcase
    w_m8     = w_base << req_addr[1:0];
    w_d64    = {32'h0000_0000, req_data} << {req_addr[1:0], 3'b000};
    w_cross  = |w_m8[7:4];
    w_reject = !w_op_ok || (w_cross && (SPLIT_MISALIGNED == 0));
  end

  // Next-state and next-bus-beat logic; bus fields only change on a
  // handshake or an accepted first beat so they stay stable while stalled.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    hi_data_d   = hi_data_q;
    hi_mask_d   = hi_mask_q;
    cross_d     = cross_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (w_reject) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d     = ACC0;
            err_d       = 1'b0;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = w_d64[31:0];
            mem_wmask_d = w_m8[3:0];
            hi_data_d   = w_d64[63:32];
            hi_mask_d   = w_m8[7:4];
            cross_d     = w_cross;
          end
        end
      end
      ACC0: begin
        if (mem_ready) begin
          if (cross_q) begin
            state_d     = ACC1;
            mem_addr_d  = mem_addr_q + 32'd4;
            mem_wdata_d = hi_data_q;
            mem_wmask_d = hi_mask_q;
          end else begin
            state_d = RESP;
          end
        end
      end
      ACC1: begin
        if (mem_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and bus-field registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wmask_q <= 4'h0;
      hi_data_q   <= 32'h0;
      hi_mask_q   <= 4'h0;
      cross_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      hi_data_q   <= hi_data_d;
      hi_mask_q   <= hi_mask_d;
      cross_q     <= cross_d;
      err_q       <= err_d;
    end
  end

  // Handshake and response outputs decoded from the current state.
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_valid = (state_q == ACC0) || (state_q == ACC1);
    done      = (state_q == RESP);
    err       = (state_q == RESP) && err_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_wmask = mem_wmask_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_store_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_sequencer
// Description : Self-checking bench for store_sequencer: directed scenarios
//               plus randomized stores against a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_sequencer;

  localparam logic [1:0] OP_SB = 2'd0;
  localparam logic [1:0] OP_SH = 2'd1;
  localparam logic [1:0] OP_SW = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_data = 32'h0;
  logic [1:0]  req_storeop = 2'd0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        done;
  logic        err;

  logic        req_valid_n = 1'b0;
  logic        req_ready_n;
  logic [31:0] req_addr_n = 32'h0;
  logic [31:0] req_data_n = 32'h0;
  logic [1:0]  req_storeop_n = 2'd0;
  logic        mem_valid_n;
  logic        mem_ready_n = 1'b1;
  logic [31:0] mem_addr_n;
  logic [31:0] mem_wdata_n;
  logic [3:0]  mem_wmask_n;
  logic        done_n;
  logic        err_n;

  int n_total = 0;
  int n_bad   = 0;

  // expected writes for the request in flight
  logic [31:0] exp_addr [2];
  logic [31:0] exp_data [2];
  logic [3:0]  exp_mask [2];
  int          exp_n;
  logic        exp_err;

  // writes actually accepted on the bus
  logic [31:0] obs_addr [2];
  logic [31:0] obs_data [2];
  logic [3:0]  obs_mask [2];

  always #5 clk = ~clk;

  store_sequencer #(
    .SPLIT_MISALIGNED(1), .STORE_OP_WIDTH(2),
    .STORE_OP_SB(OP_SB), .STORE_OP_SH(OP_SH), .STORE_OP_SW(OP_SW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_storeop(req_storeop),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .done(done), .err(err)
  );

  store_sequencer #(
    .SPLIT_MISALIGNED(0), .STORE_OP_WIDTH(2),
    .STORE_OP_SB(OP_SB), .STORE_OP_SH(OP_SH), .STORE_OP_SW(OP_SW)
  ) dut_n (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_n), .req_ready(req_ready_n),
    .req_addr(req_addr_n), .req_data(req_data_n), .req_storeop(req_storeop_n),
    .mem_valid(mem_valid_n), .mem_ready(mem_ready_n),
    .mem_addr(mem_addr_n), .mem_wdata(mem_wdata_n), .mem_wmask(mem_wmask_n),
    .done(done_n), .err(err_n)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: place each data byte at its absolute byte position
  // across two consecutive words; only the first n bytes enable lanes.
  task automatic build_expect(input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] op, input bit split);
    int   n;
    int   off;
    int   pos;
    bit   crossing;
    n   = (op == OP_SB) ? 1 : (op == OP_SH) ? 2 : (op == OP_SW) ? 4 : 0;
    off = int'(a % 4);
    exp_addr[0] = a - 32'(off);
    exp_addr[1] = a - 32'(off) + 32'd4;
    for (int w = 0; w < 2; w++) begin
      exp_data[w] = 32'h0;
      exp_mask[w] = 4'h0;
    end
    for (int i = 0; i < 4; i++) begin
      pos = off + i;
      exp_data[pos / 4][(pos % 4) * 8 +: 8] = d[i * 8 +: 8];
      if (i < n) exp_mask[pos / 4][pos % 4] = 1'b1;
    end
    crossing = (off + n) > 4;
    exp_err  = (n == 0) || (crossing && !split);
    exp_n    = exp_err ? 0 : (crossing ? 2 : 1);
  endtask

  // Issue one store on the split-enabled instance and follow it to done.
  task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] op, input int stall_first,
                           input bit rnd, output int lat, output int nw);
    int stall_left;
    int nstall;
    int vcyc;
    int idx;
    build_expect(a, d, op, 1'b1);
    check("ready_before", req_ready, 1);
    req_valid   = 1'b1;
    req_addr    = a;
    req_data    = d;
    req_storeop = op;
    mem_ready   = 1'($urandom);
    step();
    req_valid   = 1'b0;
    req_addr    = $urandom;
    req_data    = $urandom;
    req_storeop = 2'($urandom);
    nw = 0; lat = 0; vcyc = 0; nstall = 0;
    stall_left = stall_first;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      if (mem_valid) begin
        vcyc++;
        idx = (nw < 2) ? nw : 1;
        check("busy_ready", req_ready, 0);
        check("done_in_acc", done, 0);
        check("wr_in_range", nw < exp_n, 1);
        check("wr_addr", mem_addr, exp_addr[idx]);
        check("wr_data", mem_wdata, exp_data[idx]);
        check("wr_mask", mem_wmask, exp_mask[idx]);
        check("wr_mask_nz", mem_wmask != 4'h0, 1);
        if (stall_left > 0) begin
          mem_ready = 1'b0;
          stall_left--;
        end else if (rnd) begin
          mem_ready = ($urandom_range(0, 3) != 0);
        end else begin
          mem_ready = 1'b1;
        end
        if (mem_ready) begin
          obs_addr[idx] = mem_addr;
          obs_data[idx] = mem_wdata;
          obs_mask[idx] = mem_wmask;
          nw++;
        end else begin
          nstall++;
        end
      end else begin
        mem_ready = 1'($urandom);
        if (done) begin
          lat = k;
          check("err", err, exp_err);
          check("n_writes", nw, exp_n);
          check("latency", lat, exp_err ? 1 : exp_n + nstall + 1);
          check("valid_cycles", vcyc, exp_n + nstall);
        end else begin
          check("stuck", {mem_valid, done} != 2'b00, 1);
        end
      end
      step();
    end
    check("timeout", lat != 0, 1);
    check("done_one_cycle", done, 0);
    check("ready_after", req_ready, 1);
    check("no_valid_after", mem_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int nw;
    logic [31:0] a;

    // reset state
    reset = 1'b1;
    step();
    step();
    check("rst_valid", mem_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wmask", mem_wmask, 0);
    reset = 1'b0;
    check("rst_release_ready", req_ready, 1);
    step();
    check("idle_ready", req_ready, 1);

    // SB at the top byte of a word
    run_store(32'h0000_1003, 32'h0000_00A5, OP_SB, 0, 1'b0, lat, nw);
    check("sb_lat", lat, 2);
    check("sb_nw", nw, 1);
    check("sb_addr", obs_addr[0], 32'h0000_1000);
    check("sb_mask", obs_mask[0], 4'b1000);
    check("sb_data", obs_data[0], 32'hA500_0000);

    // SW split across two words
    run_store(32'h0000_2002, 32'h1122_3344, OP_SW, 0, 1'b0, lat, nw);
    check("sw_lat", lat, 3);
    check("sw_nw", nw, 2);
    check("sw_addr0", obs_addr[0], 32'h0000_2000);
    check("sw_mask0", obs_mask[0], 4'b1100);
    check("sw_data0", obs_data[0], 32'h3344_0000);
    check("sw_addr1", obs_addr[1], 32'h0000_2004);
    check("sw_mask1", obs_mask[1], 4'b0011);
    check("sw_data1", obs_data[1], 32'h0000_1122);

    // SH with three stalled bus cycles
    run_store(32'h0000_0010, 32'h0000_BEEF, OP_SH, 3, 1'b0, lat, nw);
    check("sh_lat", lat, 5);
    check("sh_mask", obs_mask[0], 4'b0011);
    check("sh_data", obs_data[0], 32'h0000_BEEF);

    // SW wrapping past the top of the address space
    run_store(32'hFFFF_FFFD, 32'hCAFE_F00D, OP_SW, 0, 1'b0, lat, nw);
    check("wrap_addr0", obs_addr[0], 32'hFFFF_FFFC);
    check("wrap_mask0", obs_mask[0], 4'b1110);
    check("wrap_addr1", obs_addr[1], 32'h0000_0000);
    check("wrap_mask1", obs_mask[1], 4'b0001);

    // illegal storeop is rejected without a bus write
    run_store(32'h0000_0040, 32'h1234_5678, 2'd3, 0, 1'b0, lat, nw);
    check("badop_lat", lat, 1);
    check("badop_nw", nw, 0);

    // crossing SH on the non-splitting instance is rejected
    req_valid_n   = 1'b1;
    req_addr_n    = 32'h0000_0007;
    req_data_n    = 32'h0000_1234;
    req_storeop_n = OP_SH;
    step();
    req_valid_n = 1'b0;
    check("nosplit_valid", mem_valid_n, 0);
    check("nosplit_done", done_n, 1);
    check("nosplit_err", err_n, 1);
    step();
    check("nosplit_done_off", done_n, 0);
    check("nosplit_valid2", mem_valid_n, 0);
    check("nosplit_ready", req_ready_n, 1);

    // reset during a stalled second beat abandons the store
    req_valid   = 1'b1;
    req_addr    = 32'h0000_2002;
    req_data    = 32'h1122_3344;
    req_storeop = OP_SW;
    step();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    step();
    check("rst_acc1_valid", mem_valid, 1);
    check("rst_acc1_addr", mem_addr, 32'h0000_2004);
    mem_ready = 1'b0;
    reset     = 1'b1;
    req_valid = 1'b1;
    step();
    check("rst_mid_valid", mem_valid, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_addr", mem_addr, 0);
    check("rst_mid_mask", mem_wmask, 0);
    reset     = 1'b0;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    check("rst_mid_ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_valid", mem_valid, 0);
      check("post_rst_done", done, 0);
    end
    check("post_rst_ready", req_ready, 1);

    // randomized stores, with random bus back-pressure and idle gaps
    for (int t = 0; t < 200; t++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      run_store(a, $urandom, 2'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), 1'b1, lat, nw);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        mem_ready = 1'($urandom);
        step();
        check("gap_valid", mem_valid, 0);
        check("gap_done", done, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
